npc_ras_unit: RTL and testbench
===============================

Name: npc_ras_unit

Overview:
- Sequential next-PC generator for the IF stage. Owns the fetch PC register.
- Selects the next PC from order, branch, immediate jump, register jump, exception entry and eret sources.
- Adds a parametrised return-address stack (RAS) that tracks call/return pairs and counts return mispredictions for performance analysis.
- Sits between D-stage control (branch compare, decoded jump class) and the IM address port.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception request.
- RAS_DEPTH, 4, RAS entries; power of two, minimum 2.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold PC and RAS this cycle
- npc_op  in  3  D-stage class: 0 order, 1 branch, 2 jump-imm, 3 jump-reg, 4 return (jr $ra); 5-7 treated as 0
- cmp  in  1  branch condition result, valid when npc_op=1
- id_pc  in  32  PC of the D-stage control instruction
- imm16  in  16  branch offset
- jmp_addr  in  26  J-format target field
- jmp_reg  in  32  forwarded rs value
- link  in  1  D-stage instruction writes a return address (jal/jalr)
- exc_req  in  1  exception/interrupt entry
- eret_req  in  1  return from exception
- epc  in  32  exception return address
- pc  out  32  registered fetch PC
- npc  out  32  combinational next PC
- ras_top  out  32  current RAS top; 0 when empty
- ras_empty  out  1  RAS holds no entries
- pc_misalign  out  1  pc[1:0] != 0
- mispredict_cnt  out  CNT_W  count of returns whose target differed from the RAS prediction

Behaviour:
- Reset (synchronous, highest priority):
  - pc <= RESET_PC.
  - RAS count and pointer <= 0; ras_empty=1; ras_top=0.
  - mispredict_cnt <= 0.
- npc priority (combinational):
  - exc_req -> EXC_VECTOR.
  - else eret_req -> epc.
  - else by npc_op:
    - 1 with cmp=1 -> id_pc + 4 + {sext(imm16),2'b00}, mod 2^32.
    - 1 with cmp=0 -> pc + 4.
    - 2 -> {id_pc_plus4[31:28], jmp_addr, 2'b00}, where id_pc_plus4 = id_pc + 4.
    - 3 or 4 -> jmp_reg.
    - otherwise -> pc + 4.
- PC update:
  - pc <= npc when !stall or exc_req; exception entry overrides stall.
  - On eret_req with stall=1, pc holds.
  - Latency: one cycle from inputs to pc.
- RAS active condition: !reset && !stall && !exc_req && !eret_req. When inactive, the RAS and counter are unchanged.
- Push (active && link):
  - Writes id_pc + 8 (delay-slot link) at the pointer; pointer increments mod RAS_DEPTH.
  - count saturates at RAS_DEPTH.
  - When full, the push overwrites the oldest entry.
- Pop (active && npc_op==4):
  - If not empty: pointer decrements mod RAS_DEPTH; count decrements.
  - If empty: no state change.
- Mispredict (active && npc_op==4):
  - If ras_empty, or ras_top != jmp_reg, mispredict_cnt increments.
  - The counter saturates at all-ones.
  - jmp_reg is always the authoritative target.
- Simultaneous pop and push (npc_op==4 with link=1):
  - Pop first, then push; the top entry is replaced by id_pc+8.
  - count is unchanged, except from empty, where it goes to 1.
- Push with npc_op 1/2/3 is a plain push.
- Misaligned jmp_reg is loaded as-is; pc_misalign reports it. No internal trap.
- Overflow: the pointer wraps, so after more than RAS_DEPTH nested calls the oldest return addresses are lost. The next pops return the latest RAS_DEPTH entries in LIFO order.

Test Plan:
- Reset, then 3 cycles with op=0, no stall -> pc 0x3000, 0x3004, 0x3008, 0x300C; ras_empty=1; mispredict_cnt=0.
- Branch: id_pc=0x3010, op=1, cmp=1, imm16=0xFFFC -> pc=0x3004. Same with cmp=0 from pc=0x3014 -> pc=0x3018.
- jal at id_pc=0x3020 (op=2, link=1, jmp_addr=0x0000C40) -> pc=0x3100, ras_top=0x3028. Then op=4, jmp_reg=0x3028 -> pc=0x3028, ras_empty=1, mispredict_cnt=0.
- RAS overflow:
  - Push 5 links from id_pc 0x3000, 0x3010, 0x3020, 0x3030, 0x3040 with depth 4.
  - Then 5 returns with matching jmp_reg -> first 4 pop 0x3048, 0x3038, 0x3028, 0x3018.
  - Fifth return sees empty -> mispredict_cnt=1.
- Stall with op=2 -> pc and RAS unchanged. exc_req with stall=1 -> pc=0x4180, no push even with link=1. eret_req, epc=0x3204 -> pc=0x3204.
- op=3, jmp_reg=0x3002 -> pc=0x3002, pc_misalign=1. Assert reset mid-sequence with a non-empty RAS -> next cycle pc=0x3000, ras_empty=1, counter 0.

Source files
------------

// File: rtl/npc_ras_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// npc_ras_unit - fetch PC register, next-PC select and return-address stack
// Revision: 1.0
//------------------------------------------------------------------------------
module npc_ras_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          RAS_DEPTH  = 4,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic [2:0]       npc_op_i,
  input  logic             cmp_i,
  input  logic [31:0]      id_pc_i,
  input  logic [15:0]      imm16_i,
  input  logic [25:0]      jmp_addr_i,
  input  logic [31:0]      jmp_reg_i,
  input  logic             link_i,
  input  logic             exc_req_i,
  input  logic             eret_req_i,
  input  logic [31:0]      epc_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      npc_o,
  output logic [31:0]      ras_top_o,
  output logic             ras_empty_o,
  output logic             pc_misalign_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int               c_PTR_W  = $clog2(RAS_DEPTH);
  localparam int               c_CNT_W  = $clog2(RAS_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(RAS_DEPTH);
  localparam logic [2:0]       c_OP_BR  = 3'd1;
  localparam logic [2:0]       c_OP_JI  = 3'd2;
  localparam logic [2:0]       c_OP_JR  = 3'd3;
  localparam logic [2:0]       c_OP_RET = 3'd4;

  logic [31:0]        pc_q;
  logic [31:0]        ras_mem_q [RAS_DEPTH];
  logic [c_PTR_W-1:0] ptr_q, ptr_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   mis_q, mis_d;

  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_id_plus4;
  logic [31:0]        w_br_tgt;
  logic [31:0]        w_j_tgt;
  logic [31:0]        w_npc;
  logic [c_PTR_W-1:0] w_top_idx;
  logic               w_empty;
  logic [31:0]        w_top;
  logic               w_active;
  logic               w_ret;
  logic               w_pop;
  logic               w_push;
  logic [c_PTR_W-1:0] w_ptr_pop;
  logic [c_CNT_W-1:0] w_cnt_pop;

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_id_plus4 = id_pc_i + 32'd4;
  assign w_br_tgt   = w_id_plus4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign w_j_tgt    = {w_id_plus4[31:28], jmp_addr_i, 2'b00};

  always_comb begin
    w_npc = w_pc_plus4;
    if (exc_req_i) begin
      w_npc = EXC_VECTOR;
    end else if (eret_req_i) begin
      w_npc = epc_i;
    end else begin
      case (npc_op_i)
        c_OP_BR:           w_npc = cmp_i ? w_br_tgt : w_pc_plus4;
        c_OP_JI:           w_npc = w_j_tgt;
        c_OP_JR, c_OP_RET: w_npc = jmp_reg_i;
        default:           w_npc = w_pc_plus4;
      endcase
    end
  end

  // Top lives one slot below the write pointer; power-of-two depth makes the wrap free.
  assign w_top_idx = ptr_q - c_PTR_W'(1);
  assign w_empty   = (cnt_q == '0);
  assign w_top     = w_empty ? 32'd0 : ras_mem_q[w_top_idx];

  assign w_active  = !reset_i && !stall_i && !exc_req_i && !eret_req_i;
  assign w_ret     = w_active && (npc_op_i == c_OP_RET);
  assign w_pop     = w_ret && !w_empty;
  assign w_push    = w_active && link_i;
  assign w_ptr_pop = w_pop ? w_top_idx : ptr_q;
  assign w_cnt_pop = w_pop ? (cnt_q - c_CNT_W'(1)) : cnt_q;

  // A return with link pops first and then pushes, so the top entry is replaced.
  always_comb begin
    ptr_d = w_ptr_pop;
    cnt_d = w_cnt_pop;
    mis_d = mis_q;
    if (w_push) begin
      ptr_d = w_ptr_pop + c_PTR_W'(1);
      cnt_d = (w_cnt_pop == c_FULL) ? c_FULL : (w_cnt_pop + c_CNT_W'(1));
    end
    if (w_ret && (w_empty || (w_top != jmp_reg_i)) && (mis_q != '1)) begin
      mis_d = mis_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      mis_q <= '0;
    end else begin
      if (!stall_i || exc_req_i) begin
        pc_q <= w_npc;
      end
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  // Entries are only read while counted as valid, so the storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      ras_mem_q[w_ptr_pop] <= w_id_plus4 + 32'd4;
    end
  end

  assign pc_o             = pc_q;
  assign npc_o            = w_npc;
  assign ras_top_o        = w_top;
  assign ras_empty_o      = w_empty;
  assign pc_misalign_o    = |pc_q[1:0];
  assign mispredict_cnt_o = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_npc_ras_unit.sv
`default_nettype none
// Bench for npc_ras_unit: directed plan steps then random traffic against a queue-based model.
module tb_npc_ras_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam int          DEPTH  = 4;
  localparam int          CW     = 16;

  logic          clk = 1'b0;
  logic          reset, stall, cmp, link, exc_req, eret_req;
  logic [2:0]    npc_op;
  logic [31:0]   id_pc, jmp_reg, epc;
  logic [15:0]   imm16;
  logic [25:0]   jmp_addr;
  logic [31:0]   pc, npc, ras_top;
  logic          ras_empty, pc_misalign;
  logic [CW-1:0] mispredict_cnt;

  always #5 clk = ~clk;

  npc_ras_unit #(
    .RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC), .RAS_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .npc_op_i(npc_op), .cmp_i(cmp),
    .id_pc_i(id_pc), .imm16_i(imm16), .jmp_addr_i(jmp_addr), .jmp_reg_i(jmp_reg),
    .link_i(link), .exc_req_i(exc_req), .eret_req_i(eret_req), .epc_i(epc),
    .pc_o(pc), .npc_o(npc), .ras_top_o(ras_top), .ras_empty_o(ras_empty),
    .pc_misalign_o(pc_misalign), .mispredict_cnt_o(mispredict_cnt)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int unsigned m_mis;
  bit          m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (exc_req) return EXC_PC;
    if (eret_req) return epc;
    case (npc_op)
      3'd1: return cmp ? (id_pc + 32'd4 + 32'(int'($signed(imm16)) * 4)) : seq;
      3'd2: return ((id_pc + 32'd4) & 32'hF000_0000) | (32'(jmp_addr) << 2);
      3'd3, 3'd4: return jmp_reg;
      default: return seq;
    endcase
  endfunction

  task automatic set_idle();
    reset = 0; stall = 0; cmp = 0; link = 0; exc_req = 0; eret_req = 0;
    npc_op = 3'd0; id_pc = 32'd0; jmp_reg = 32'd0; epc = 32'd0; imm16 = 16'd0; jmp_addr = 26'd0;
  endtask

  // Drives one clock with the current inputs, advances the model and compares everything.
  task automatic tick();
    logic [31:0] e_npc;
    bit          active;
    e_npc  = ref_npc();
    active = !reset && !stall && !exc_req && !eret_req;
    #1;
    if (m_valid) chk("npc", npc, e_npc);
    @(posedge clk);
    #1;
    if (reset) begin
      m_pc = RST_PC;
      m_ras.delete();
      m_mis = 0;
      m_valid = 1'b1;
    end else begin
      if (!stall || exc_req) m_pc = e_npc;
      if (active && npc_op == 3'd4) begin
        if (m_ras.size() == 0 || m_ras[$] != jmp_reg) begin
          if (m_mis < 32'hFFFF) m_mis++;
        end
        if (m_ras.size() != 0) void'(m_ras.pop_back());
      end
      if (active && link) begin
        m_ras.push_back(id_pc + 32'd8);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
    chk("pc", pc, m_pc);
    chk("ras_top", ras_top, (m_ras.size() == 0) ? 32'd0 : m_ras[$]);
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("misalign", 32'(pc_misalign), 32'(m_pc[1:0] != 2'b00));
    chk("mis_cnt", 32'(mispredict_cnt), m_mis);
  endtask

  initial begin
    set_idle();
    reset = 1; tick();
    chk("plan_reset_pc", pc, 32'h3000);
    set_idle();
    tick(); chk("plan_seq1", pc, 32'h3004);
    tick(); chk("plan_seq2", pc, 32'h3008);
    tick(); chk("plan_seq3", pc, 32'h300C);

    set_idle(); npc_op = 3'd1; cmp = 1; id_pc = 32'h3010; imm16 = 16'hFFFC; tick();
    chk("plan_br_taken", pc, 32'h3004);
    set_idle(); npc_op = 3'd3; jmp_reg = 32'h3014; tick();
    set_idle(); npc_op = 3'd1; cmp = 0; id_pc = 32'h3010; imm16 = 16'hFFFC; tick();
    chk("plan_br_not_taken", pc, 32'h3018);

    set_idle(); npc_op = 3'd2; link = 1; id_pc = 32'h3020; jmp_addr = 26'h0000C40; tick();
    chk("plan_jal_pc", pc, 32'h3100);
    chk("plan_jal_top", ras_top, 32'h3028);
    set_idle(); npc_op = 3'd4; jmp_reg = 32'h3028; tick();
    chk("plan_ret_pc", pc, 32'h3028);
    chk("plan_ret_empty", 32'(ras_empty), 32'd1);
    chk("plan_ret_cnt", 32'(mispredict_cnt), 32'd0);

    for (int i = 0; i < 5; i++) begin
      set_idle(); link = 1; id_pc = 32'h3000 + 32'(i) * 32'h10; tick();
    end
    chk("plan_ovf_top", ras_top, 32'h3048);
    for (int i = 0; i < 5; i++) begin
      set_idle(); npc_op = 3'd4;
      jmp_reg = (i < 4) ? (32'h3048 - 32'(i) * 32'h10) : 32'h3008;
      tick();
    end
    chk("plan_ovf_mis", 32'(mispredict_cnt), 32'd1);

    set_idle(); link = 1; id_pc = 32'h3100; tick();
    set_idle(); stall = 1; npc_op = 3'd2; link = 1; id_pc = 32'h3200; jmp_addr = 26'h0000C40; tick();
    chk("plan_stall_pc", pc, 32'h300C);
    chk("plan_stall_top", ras_top, 32'h3108);
    set_idle(); stall = 1; exc_req = 1; link = 1; id_pc = 32'h3300; tick();
    chk("plan_exc_pc", pc, 32'h4180);
    chk("plan_exc_top", ras_top, 32'h3108);
    set_idle(); eret_req = 1; epc = 32'h3204; tick();
    chk("plan_eret_pc", pc, 32'h3204);
    set_idle(); npc_op = 3'd3; jmp_reg = 32'h3002; tick();
    chk("plan_misalign", 32'(pc_misalign), 32'd1);
    set_idle(); reset = 1; npc_op = 3'd2; link = 1; tick();
    chk("plan_rst_pc", pc, 32'h3000);
    chk("plan_rst_empty", 32'(ras_empty), 32'd1);

    for (int i = 0; i < 400; i++) begin
      set_idle();
      reset    = ($urandom_range(0, 63) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      exc_req  = ($urandom_range(0, 19) == 0);
      eret_req = ($urandom_range(0, 19) == 0);
      npc_op   = 3'($urandom_range(0, 7));
      cmp      = 1'($urandom);
      link     = ($urandom_range(0, 2) == 0);
      id_pc    = $urandom & 32'hFFFF_FFFC;
      imm16    = 16'($urandom);
      jmp_addr = 26'($urandom);
      jmp_reg  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      epc      = $urandom & 32'hFFFF_FFFC;
      if (npc_op == 3'd4 && m_ras.size() != 0 && $urandom_range(0, 3) != 0) jmp_reg = m_ras[$];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
